fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 2-stage pipelined 4-bit CPU; directly upstream of the execute/ALU stage.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 18 +
 rtl/imem16x8.sv | 23 ++
 rtl/fetch_stage.sv | 50 +++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU pipeline. The fetch and execute
// stages take their widths, opcodes and bubble word from here.
package cpu_pkg;
  localparam int DATA_W = 4;
  localparam int INSN_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [INSN_W-1:0] NOP_INSN = 8'h00;
  localparam logic [3:0]        OP_JMP   = 4'hF;
  localparam logic [3:0]        OP_JNC   = 4'hE;

  typedef logic [INSN_W-1:0] insn_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    logic  we;
    addr_t addr;
    insn_t data;
  } prog_req_t;

  // A jump is taken when it is unconditional, or when it is JNC and carry is clear.
  function automatic logic is_taken(input insn_t insn, input logic cflag);
    return (insn[7:4] == OP_JMP) || ((insn[7:4] == OP_JNC) && !cflag);
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: program-load port, run control, carry feedback and the
// instruction word handed to execute.
interface fetch_stage_if;
  import cpu_pkg::*;
  logic  run;
  logic  prog_we;
  addr_t prog_addr;
  insn_t prog_data;
  logic  cflag;
  insn_t D_BUS;
  addr_t pc;
  logic  squash;

  modport master (output run, prog_we, prog_addr, prog_data, cflag,
                  input  D_BUS, pc, squash);
  modport slave  (input  run, prog_we, prog_addr, prog_data, cflag,
                  output D_BUS, pc, squash);
endinterface

// File: rtl/imem16x8.sv
// 16x8 instruction store: cleared to the bubble word on reset, synchronous
// write, combinational read.
module imem16x8
  import cpu_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  prog_req_t wr,
  input  addr_t     raddr,
  output insn_t     rdata
);
  insn_t mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_INSN;
    end else if (wr.we) begin
      mem[wr.addr] <= wr.data;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, instruction memory and D_BUS register. Jumps are
// resolved while they sit on D_BUS; a taken jump replaces the wrong-path fetch with a bubble.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  fetch_stage_if.slave        bus
);
  addr_t     pc_q;
  insn_t     d_bus_q;
  insn_t     imem_rd;
  prog_req_t wr;
  logic      taken;

  // Writes only land while stalled, so a fetch never reads a word being written.
  assign wr.we   = bus.prog_we & ~bus.run;
  assign wr.addr = bus.prog_addr;
  assign wr.data = bus.prog_data;

  imem16x8 u_imem (
    .clock (clock),
    .reset (reset),
    .wr    (wr),
    .raddr (pc_q),
    .rdata (imem_rd)
  );

  assign taken = is_taken(d_bus_q, bus.cflag);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      d_bus_q <= NOP_INSN;
    end else if (taken) begin
      // Redirect wins over stall so a jump parked on D_BUS is never lost.
      pc_q    <= d_bus_q[3:0];
      d_bus_q <= NOP_INSN;
    end else if (bus.run) begin
      pc_q    <= pc_q + addr_t'(1);
      d_bus_q <= imem_rd;
    end else begin
      d_bus_q <= NOP_INSN;
    end
  end

  assign bus.D_BUS  = d_bus_q;
  assign bus.pc     = pc_q;
  assign bus.squash = taken;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed tables, hand sequences for
// stall/jump/reset corners, and a randomized run against a cycle model.
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_stage_if bus();
  fetch_stage dut (.clock(clock), .reset(reset), .bus(bus.slave));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: what the stage should hold, derived from the fetch rules.
  logic [7:0] m_mem [16];
  logic [3:0] m_pc;
  logic [7:0] m_d;

  typedef struct {
    logic       run;
    logic [7:0] d;
    logic [3:0] pc;
    logic       sq;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_squash(input logic c);
    int op;
    op = int'(m_d[7:4]);
    return (op == 15) || (op == 14 && !c);
  endfunction

  task automatic m_clear();
    m_pc = 4'd0;
    m_d  = 8'h00;
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
  endtask

  // Async reset pulse placed mid-cycle, between clock edges.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    m_clear();
    chk("reset_pc", {4'h0, bus.pc}, 8'h00);
    chk("reset_dbus", bus.D_BUS, 8'h00);
    #2 reset = 1'b1;
  endtask

  task automatic tick(input logic run, input logic c, input logic we = 1'b0,
                      input logic [3:0] addr = 4'h0, input logic [7:0] data = 8'h00);
    logic sq;
    bus.run = run; bus.cflag = c; bus.prog_we = we;
    bus.prog_addr = addr; bus.prog_data = data;
    #1;
    sq = m_squash(c);
    chk("squash", {7'd0, bus.squash}, {7'd0, sq});
    @(posedge clock);
    if (sq) begin
      m_pc = m_d[3:0];
      m_d  = 8'h00;
    end else if (run) begin
      m_d  = m_mem[m_pc];
      m_pc = 4'((int'(m_pc) + 1) % 16);
    end else begin
      m_d  = 8'h00;
    end
    if (we && !run) m_mem[addr] = data;
    #1;
    chk("pc", {4'h0, bus.pc}, {4'h0, m_pc});
    chk("dbus", bus.D_BUS, m_d);
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    tick(1'b0, 1'b1, 1'b1, a, d);
  endtask

  initial begin
    logic [7:0] w;
    bus.run = 1'b0; bus.cflag = 1'b1; bus.prog_we = 1'b0;
    bus.prog_addr = 4'h0; bus.prog_data = 8'h00;
    m_clear();
    #3;
    chk("por_pc", {4'h0, bus.pc}, 8'h00);
    chk("por_dbus", bus.D_BUS, 8'h00);
    @(posedge clock); #1;
    reset = 1'b1;

    // Straight-line fetch then a JMP 2 at address 5.
    tbl[0] = '{1'b1, 8'h00, 4'd1, 1'b0};
    tbl[1] = '{1'b1, 8'h11, 4'd2, 1'b0};
    tbl[2] = '{1'b1, 8'h22, 4'd3, 1'b0};
    tbl[3] = '{1'b1, 8'h33, 4'd4, 1'b0};
    tbl[4] = '{1'b1, 8'h44, 4'd5, 1'b0};
    tbl[5] = '{1'b1, 8'hF2, 4'd6, 1'b1};
    tbl[6] = '{1'b1, 8'h00, 4'd2, 1'b0};
    tbl[7] = '{1'b1, 8'h22, 4'd3, 1'b0};
    tbl[8] = '{1'b1, 8'h33, 4'd4, 1'b0};
    load(4'd0, 8'h00); load(4'd1, 8'h11); load(4'd2, 8'h22);
    load(4'd3, 8'h33); load(4'd4, 8'h44); load(4'd5, 8'hF2);
    chk("pre_run_dbus", bus.D_BUS, 8'h00);
    chk("pre_run_pc", {4'h0, bus.pc}, 8'h00);
    for (int i = 0; i < 9; i++) begin
      tick(tbl[i].run, 1'b1);
      chk($sformatf("tbl%0d_dbus", i), bus.D_BUS, tbl[i].d);
      chk($sformatf("tbl%0d_pc", i), {4'h0, bus.pc}, {4'h0, tbl[i].pc});
      chk($sformatf("tbl%0d_sq", i), {7'd0, bus.squash}, {7'd0, tbl[i].sq});
    end

    // Stall for 3 cycles at pc=4: bubbles, pc frozen, then resume at imem[4].
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      chk("stall_dbus", bus.D_BUS, 8'h00);
      chk("stall_pc", {4'h0, bus.pc}, 8'h04);
    end
    tick(1'b1, 1'b1);
    chk("resume_dbus", bus.D_BUS, 8'h44);

    // JNC 7 with carry set falls through.
    do_reset();
    load(4'd1, 8'hE7); load(4'd2, 8'h2C); load(4'd7, 8'h7C);
    tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    chk("jnc_c1_sq", {7'd0, bus.squash}, 8'h00);
    tick(1'b1, 1'b1);
    chk("jnc_c1_dbus", bus.D_BUS, 8'h2C);
    // JNC 7 with carry clear redirects.
    do_reset();
    load(4'd1, 8'hE7); load(4'd2, 8'h2C); load(4'd7, 8'h7C);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0);
    chk("jnc_c0_sq", {7'd0, bus.squash}, 8'h01);
    tick(1'b1, 1'b0);
    chk("jnc_c0_dbus", bus.D_BUS, 8'h00);
    chk("jnc_c0_pc", {4'h0, bus.pc}, 8'h07);
    tick(1'b1, 1'b0);
    chk("jnc_c0_tgt", bus.D_BUS, 8'h7C);

    // Jump on D_BUS while stalled still redirects; prog_we during run is ignored.
    do_reset();
    load(4'd0, 8'hF9); load(4'd9, 8'h5A); load(4'hA, 8'h3C);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("stall_jmp_pc", {4'h0, bus.pc}, 8'h09);
    tick(1'b0, 1'b1);
    chk("stall_jmp_hold", {4'h0, bus.pc}, 8'h09);
    tick(1'b1, 1'b1, 1'b1, 4'hA, 8'hAA);
    chk("resume9_dbus", bus.D_BUS, 8'h5A);
    tick(1'b1, 1'b1);
    chk("we_ignored", bus.D_BUS, 8'h3C);

    // Reset mid-run clears memory; jump to F then wrap to 0.
    tick(1'b1, 1'b1);
    do_reset();
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("cleared_mem", bus.D_BUS, 8'h00);
    do_reset();
    load(4'd0, 8'hFF); load(4'hF, 8'h77);
    tick(1'b1, 1'b1); tick(1'b1, 1'b1);
    chk("to_f_pc", {4'h0, bus.pc}, 8'h0F);
    tick(1'b1, 1'b1);
    chk("wrap_dbus", bus.D_BUS, 8'h77);
    chk("wrap_pc", {4'h0, bus.pc}, 8'h00);

    // Randomized programs, stalls, loads, carries and resets against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int a = 0; a < 16; a++) begin
        w = 8'($urandom);
        case ($urandom_range(0, 5))
          0: w[7:4] = 4'hF;
          1: w[7:4] = 4'hE;
          2: w = 8'h00;
          default: ;
        endcase
        load(4'(a), w);
      end
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 7) == 0)
          tick(1'b0, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
        else
          tick(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
